// File: rtl/exu_stage_mc_if.sv
// rtl/exu_stage_mc_if.sv - bundle of decode, memory-stage, bypass and data SRAM signals for exu_stage_mc
//
// Purpose: groups every non-clock/reset signal of the execute stage.
//   master : decode / memory-stage side (drives in_*, flush, out_allow_in)
//   slave  : the execute stage itself
// Signals:
//   flush, in_valid, allow_in, in_pc, in_op, in_src1, in_src2, in_store_data,
//   in_mem_we, in_res_from_mem, in_mem_size, in_gr_we, in_dest      decode side
//   out_allow_in, out_valid, out_pc, out_result, out_res_from_mem,
//   out_gr_we, out_mem_size, out_dest                               memory side
//   fwd_valid, fwd_gr_we, fwd_dest, fwd_data, fwd_is_ld, fwd_busy   bypass to decode
//   data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata     data SRAM request
interface exu_stage_mc_if #(
  parameter int XLEN = 32
);
  localparam int BE_W = XLEN / 8;

  logic            flush;
  logic            in_valid;
  logic            allow_in;
  logic [XLEN-1:0] in_pc;
  logic [3:0]      in_op;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic [XLEN-1:0] in_store_data;
  logic            in_mem_we;
  logic            in_res_from_mem;
  logic [1:0]      in_mem_size;
  logic            in_gr_we;
  logic [4:0]      in_dest;

  logic            out_allow_in;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_result;
  logic            out_res_from_mem;
  logic            out_gr_we;
  logic [1:0]      out_mem_size;
  logic [4:0]      out_dest;

  logic            fwd_valid;
  logic            fwd_gr_we;
  logic [4:0]      fwd_dest;
  logic [XLEN-1:0] fwd_data;
  logic            fwd_is_ld;
  logic            fwd_busy;

  logic            data_sram_en;
  logic [BE_W-1:0] data_sram_we;
  logic [XLEN-1:0] data_sram_addr;
  logic [XLEN-1:0] data_sram_wdata;

  modport master (
    output flush, in_valid, in_pc, in_op, in_src1, in_src2, in_store_data,
           in_mem_we, in_res_from_mem, in_mem_size, in_gr_we, in_dest, out_allow_in,
    input  allow_in, out_valid, out_pc, out_result, out_res_from_mem, out_gr_we,
           out_mem_size, out_dest, fwd_valid, fwd_gr_we, fwd_dest, fwd_data,
           fwd_is_ld, fwd_busy, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport slave (
    input  flush, in_valid, in_pc, in_op, in_src1, in_src2, in_store_data,
           in_mem_we, in_res_from_mem, in_mem_size, in_gr_we, in_dest, out_allow_in,
    output allow_in, out_valid, out_pc, out_result, out_res_from_mem, out_gr_we,
           out_mem_size, out_dest, fwd_valid, fwd_gr_we, fwd_dest, fwd_data,
           fwd_is_ld, fwd_busy, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );
endinterface

// File: rtl/exu_stage_mc.sv
// rtl/exu_stage_mc.sv - in-order execute stage with iterative divider, sized stores and flush
//
// Purpose: single-entry execute stage between decode and memory. ALU ops complete
// in one cycle; divide/modulo ops run a restoring divider (IDLE -> BUSY -> DONE)
// and hold the stage via ready_go. Issues the data SRAM request and bypass info.
// Ports:
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : exu_stage_mc_if.slave (decode handshake, memory handshake, bypass, SRAM)
module exu_stage_mc #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input logic           clk,
  input logic           reset,
  exu_stage_mc_if.slave bus
);
  localparam int SHW  = $clog2(XLEN);
  localparam int OFFW = $clog2(BE_W);
  localparam int CW   = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic            valid;
  logic [XLEN-1:0] pc;
  logic [3:0]      op;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic [XLEN-1:0] store_data;
  logic            mem_we;
  logic            res_from_mem;
  logic [1:0]      mem_size;
  logic            gr_we;
  logic [4:0]      dest;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] dvs;

  logic            is_div;
  logic            signed_div;
  logic            neg1;
  logic            neg2;
  logic [XLEN-1:0] mag1;
  logic [XLEN-1:0] mag2;
  logic [XLEN:0]   sh;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] div_res;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result;
  logic            ready_go;
  logic            handoff;
  logic            allow;
  logic            capture;
  logic            sram_en;
  logic [SHW-1:0]  shamt;
  logic [OFFW-1:0] lane_mask;
  logic [OFFW-1:0] off;
  logic [BE_W-1:0] base_we;
  logic [XLEN-1:0] wdata;

  // ops 12..15 are DIV/DIVU/MOD/MODU; bit0 set means unsigned, bit1 set means remainder
  assign is_div     = (op[3:2] == 2'b11);
  assign signed_div = is_div && !op[0];
  assign neg1       = signed_div && src1[XLEN-1];
  assign neg2       = signed_div && src2[XLEN-1];
  assign mag1       = neg1 ? -src1 : src1;
  assign mag2       = neg2 ? -src2 : src2;

  // restoring step: shift next dividend bit into the partial remainder, try subtract
  assign sh   = {rem, quot[XLEN-1]};
  assign diff = sh - {1'b0, dvs};

  // MIN/-1 falls out of the magnitude arithmetic (|MIN| / 1 = MIN, signs cancel);
  // divide by zero is forced so the signed case does not negate the all-ones quotient
  always_comb begin
    div_res = '0;
    if (op[1]) begin
      if (src2 == '0) div_res = src1;
      else            div_res = neg1 ? -rem : rem;
    end else begin
      if (src2 == '0) div_res = '1;
      else            div_res = (neg1 ^ neg2) ? -quot : quot;
    end
  end

  assign shamt = src2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (op)
      4'd0:    alu_res = src1 + src2;
      4'd1:    alu_res = src1 - src2;
      4'd2:    alu_res = {{(XLEN-1){1'b0}}, ($signed(src1) < $signed(src2))};
      4'd3:    alu_res = {{(XLEN-1){1'b0}}, (src1 < src2)};
      4'd4:    alu_res = src1 & src2;
      4'd5:    alu_res = src1 | src2;
      4'd6:    alu_res = src1 ^ src2;
      4'd7:    alu_res = ~(src1 | src2);
      4'd8:    alu_res = src1 << shamt;
      4'd9:    alu_res = src1 >> shamt;
      4'd10:   alu_res = $unsigned($signed(src1) >>> shamt);
      4'd11:   alu_res = src2;
      default: alu_res = '0;
    endcase
  end

  assign result   = is_div ? div_res : alu_res;
  assign ready_go = !is_div || (state == S_DONE);
  assign handoff  = valid && ready_go && bus.out_allow_in;
  assign allow    = !valid || handoff;
  assign capture  = allow && bus.in_valid && !bus.flush;
  assign sram_en  = handoff && !bus.flush && (mem_we || res_from_mem);

  // byte enables: access width is 2^size bytes, offset aligned down to that width
  assign lane_mask = OFFW'((1 << mem_size) - 1);
  assign off       = result[OFFW-1:0] & ~lane_mask;
  assign base_we   = BE_W'((1 << (1 << mem_size)) - 1);

  always_comb begin
    wdata = store_data;
    case (mem_size)
      2'd0:    wdata = {BE_W{store_data[7:0]}};
      2'd1:    wdata = {(XLEN/16){store_data[15:0]}};
      2'd2:    wdata = {(XLEN/32){store_data[31:0]}};
      default: wdata = store_data;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid        <= 1'b0;
      pc           <= '0;
      op           <= '0;
      src1         <= '0;
      src2         <= '0;
      store_data   <= '0;
      mem_we       <= 1'b0;
      res_from_mem <= 1'b0;
      mem_size     <= '0;
      gr_we        <= 1'b0;
      dest         <= '0;
    end else begin
      if (bus.flush)  valid <= 1'b0;
      else if (allow) valid <= bus.in_valid;
      if (capture) begin
        pc           <= bus.in_pc;
        op           <= bus.in_op;
        src1         <= bus.in_src1;
        src2         <= bus.in_src2;
        store_data   <= bus.in_store_data;
        mem_we       <= bus.in_mem_we;
        res_from_mem <= bus.in_res_from_mem;
        mem_size     <= bus.in_mem_size;
        gr_we        <= bus.in_gr_we;
        dest         <= bus.in_dest;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quot  <= '0;
      dvs   <= '0;
    end else if (bus.flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid && is_div) begin
            rem   <= '0;
            quot  <= mag1;
            dvs   <= mag2;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          rem  <= diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
          quot <= {quot[XLEN-2:0], !diff[XLEN]};
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_allow_in) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.allow_in         = allow;
  assign bus.out_valid        = valid && ready_go && !bus.flush;
  assign bus.out_pc           = pc;
  assign bus.out_result       = result;
  assign bus.out_res_from_mem = res_from_mem;
  assign bus.out_gr_we        = gr_we;
  assign bus.out_mem_size     = mem_size;
  assign bus.out_dest         = dest;

  assign bus.fwd_valid        = valid;
  assign bus.fwd_gr_we        = gr_we;
  assign bus.fwd_dest         = dest;
  assign bus.fwd_data         = result;
  assign bus.fwd_is_ld        = valid && res_from_mem;
  assign bus.fwd_busy         = valid && is_div && !ready_go;

  assign bus.data_sram_en     = sram_en;
  assign bus.data_sram_we     = (sram_en && mem_we) ? (base_we << off) : '0;
  assign bus.data_sram_addr   = result;
  assign bus.data_sram_wdata  = wdata;
endmodule

// File: tb/tb_exu_stage_mc.sv
// tb/tb_exu_stage_mc.sv - self-checking bench for exu_stage_mc with a behavioural reference model
module tb_exu_stage_mc;
  localparam int XLEN = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  exu_stage_mc_if #(.XLEN(XLEN)) bus ();

  exu_stage_mc #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // reference arithmetic straight from the op table using plain integer operators
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sb;
    logic min_m1;
    sa = a;
    sb = b;
    min_m1 = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~(a | b);
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return 32'(sa >>> b[4:0]);
      4'd11: return b;
      4'd12: return (b == 0) ? 32'hFFFF_FFFF : (min_m1 ? 32'h8000_0000 : 32'(sa / sb));
      4'd13: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      4'd14: return (b == 0) ? a : (min_m1 ? 32'd0 : 32'(sa % sb));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic [3:0] ref_we(input logic [1:0] size, input logic [31:0] addr);
    int n;
    logic [3:0] we;
    n = 1 << size;
    for (int i = 0; i < 4; i++) we[i] = ((i / n) == (int'(addr[1:0]) / n));
    return we;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] sd);
    int n;
    logic [31:0] w;
    n = 1 << size;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic offer(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] sd, input logic st, input logic ld,
                       input logic [1:0] size, input logic [31:0] pc, input logic [4:0] dest,
                       input logic gr);
    bus.in_valid        = 1'b1;
    bus.in_op           = op;
    bus.in_src1         = a;
    bus.in_src2         = b;
    bus.in_store_data   = sd;
    bus.in_mem_we       = st;
    bus.in_res_from_mem = ld;
    bus.in_mem_size     = size;
    bus.in_pc           = pc;
    bus.in_dest         = dest;
    bus.in_gr_we        = gr;
  endtask

  // issue one instruction, stall the memory stage for 'stall' cycles, check the handoff
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] sd, input logic st, input logic ld,
                        input logic [1:0] size, input int stall);
    logic [31:0] exp_res;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr;
    int          cyc;
    int          busy;
    int          early;
    int          exp_lat;
    bit          done;
    bit          is_div;
    pc      = $urandom;
    dest    = 5'($urandom_range(0, 31));
    gr      = 1'($urandom_range(0, 1));
    is_div  = (op >= 4'd12);
    exp_res = ref_result(op, a, b);
    exp_lat = is_div ? XLEN + 1 : 0;
    if (stall > exp_lat) exp_lat = stall;

    @(negedge clk);
    offer(op, a, b, sd, st, ld, size, pc, dest, gr);
    bus.out_allow_in = 1'b1;
    #1;
    check_eq("idle_before_issue", bus.fwd_valid, 0);
    check_eq("allow_in_accept", bus.allow_in, 1);
    @(posedge clk);

    cyc = 0; busy = 0; early = 0; done = 0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      bus.in_valid     = 1'b0;
      bus.out_allow_in = (cyc >= stall);
      #1;
      if (bus.fwd_busy) busy++;
      if (bus.out_valid && bus.out_allow_in) done = 1;
      else begin
        if (bus.data_sram_en) early++;
        cyc++;
      end
    end
    check_eq("handoff_seen", done, 1);
    if (done) begin
      check_eq("latency", cyc, exp_lat);
      check_eq("fwd_busy_cycles", busy, is_div ? XLEN + 1 : 0);
      check_eq("sram_en_while_stalled", early, 0);
      check_eq("out_result", bus.out_result, exp_res);
      check_eq("fwd_data", bus.fwd_data, exp_res);
      check_eq("sram_addr", bus.data_sram_addr, exp_res);
      check_eq("passthrough", {bus.out_pc, bus.out_dest, bus.out_gr_we, bus.out_res_from_mem,
                               bus.out_mem_size, bus.fwd_dest, bus.fwd_gr_we, bus.fwd_is_ld},
                              {pc, dest, gr, ld, size, dest, gr, ld});
      check_eq("sram_en", bus.data_sram_en, st || ld);
      check_eq("sram_we", bus.data_sram_we, st ? ref_we(size, exp_res) : 4'b0000);
      check_eq("sram_wdata", bus.data_sram_wdata, ref_wdata(size, sd));
    end
    @(posedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.out_allow_in = 1'b1;
    offer(4'd0, 0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 0);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_allow_in", bus.allow_in, 1);
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_fwd_valid", bus.fwd_valid, 0);
    check_eq("rst_sram_en", bus.data_sram_en, 0);
    check_eq("rst_sram_we", bus.data_sram_we, 0);
    reset = 1'b0;

    // directed cases
    run_op(4'd0, 32'd5, 32'd7, 0, 0, 0, 2'd2, 0);
    run_op(4'd12, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 2'd2, 0);
    run_op(4'd14, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, 2'd2, 0);
    run_op(4'd13, 32'd123, 32'd0, 0, 0, 0, 2'd2, 0);
    run_op(4'd15, 32'd9, 32'd0, 0, 0, 0, 2'd2, 0);
    run_op(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 2'd2, 0);
    run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 2'd2, 0);
    run_op(4'd0, 32'h1000, 32'd3, 32'h0000_00AB, 1, 0, 2'd0, 3);
    run_op(4'd0, 32'h2000, 32'd3, 32'h1234_5678, 1, 0, 2'd1, 1);
    run_op(4'd11, 32'd0, 32'h3006, 32'hCAFE_BEEF, 1, 0, 2'd2, 0);
    run_op(4'd0, 32'h4000, 32'd5, 0, 0, 1, 2'd2, 2);

    // back-to-back: second instruction accepted while the first hands off
    @(negedge clk);
    offer(4'd0, 32'd1, 32'd2, 0, 0, 0, 2'd2, 32'h100, 5'd1, 1);
    bus.out_allow_in = 1'b1;
    @(negedge clk);
    offer(4'd0, 32'd10, 32'd20, 0, 0, 0, 2'd2, 32'h104, 5'd2, 1);
    #1;
    check_eq("b2b_allow_in", bus.allow_in, 1);
    check_eq("b2b_first", {bus.out_valid, bus.out_result}, {1'b1, 32'd3});
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    check_eq("b2b_second", {bus.out_valid, bus.out_result, bus.out_pc}, {1'b1, 32'd30, 32'h104});
    @(negedge clk);
    #1;
    check_eq("b2b_drained", bus.fwd_valid, 0);

    // flush in BUSY cycle 10 of a divide
    offer(4'd12, 32'd1000, 32'd7, 0, 0, 0, 2'd2, 32'h200, 5'd3, 1);
    @(posedge clk);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      check_eq("pre_flush_no_out", bus.out_valid, 0);
    end
    bus.flush = 1'b1;
    #1;
    check_eq("flush_out_valid", bus.out_valid, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check_eq("flush_valid_cleared", bus.fwd_valid, 0);
    check_eq("flush_busy_cleared", bus.fwd_busy, 0);
    run_op(4'd0, 32'd40, 32'd2, 0, 0, 0, 2'd2, 0);
    run_op(4'd13, 32'd100, 32'd7, 0, 0, 0, 2'd2, 0);

    // flush on the capture cycle drops the offered instruction
    @(negedge clk);
    offer(4'd0, 32'd1, 32'd1, 0, 1, 0, 2'd2, 32'h300, 5'd4, 1);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_eq("flush_at_capture", {bus.fwd_valid, bus.out_valid, bus.data_sram_en}, 3'b000);

    // randomized instructions against the model
    for (int n = 0; n < 80; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      run_op(4'($urandom_range(0, 15)), pick_operand(), pick_operand(), $urandom,
             kind == 1, kind == 2, 2'($urandom_range(0, 2)), $urandom_range(0, 3));
    end

    // asynchronous reset while a finished divide is stalled downstream
    @(negedge clk);
    offer(4'd12, 32'd77, 32'd5, 0, 0, 0, 2'd2, 32'h400, 5'd5, 1);
    bus.out_allow_in = 1'b0;
    @(posedge clk);
    for (int i = 0; i < XLEN + 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    #1;
    check_eq("stalled_done_valid", bus.out_valid, 1);
    #1;
    reset = 1'b1;
    #1;
    check_eq("async_rst_fwd_valid", bus.fwd_valid, 0);
    check_eq("async_rst_out_valid", bus.out_valid, 0);
    check_eq("async_rst_sram_we", bus.data_sram_we, 0);
    check_eq("async_rst_allow_in", bus.allow_in, 1);
    @(negedge clk);
    reset = 1'b0;
    bus.out_allow_in = 1'b1;
    run_op(4'd12, 32'hFFFF_FF9C, 32'd7, 0, 0, 0, 2'd2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/exu_stage_mc.md
Name: exu_stage_mc

Overview:
- Parametrised execute stage for the in-order pipeline, sitting between decode and memory stages with valid/allow_in handshakes on both sides.
- Adds three things over a single-cycle execute stage:
  - a multi-cycle iterative divider that stalls the stage through ready_go;
  - sized stores with byte enables;
  - a flush input that kills the in-flight instruction.
- Drives the data SRAM request and the forwarding/load-use bypass back to decode.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- BE_W, XLEN/8: byte-enable width, derived; do not override.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- flush  in  1  kill the in-flight instruction, and any instruction being accepted in the same cycle
- in_valid  in  1  decode offers an instruction
- allow_in  out  1  stage can accept; equals !valid || (ready_go && out_allow_in)
- in_pc  in  XLEN  instruction PC
- in_op  in  4  0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 AND, 5 OR, 6 XOR, 7 NOR, 8 SLL, 9 SRL, 10 SRA, 11 PASS2, 12 DIV, 13 DIVU, 14 MOD, 15 MODU
- in_src1, in_src2  in  XLEN  operands, already muxed by decode
- in_store_data  in  XLEN  store data
- in_mem_we  in  1  store
- in_res_from_mem  in  1  load
- in_mem_size  in  2  0 byte, 1 half, 2 word, 3 dword (dword legal only when XLEN=64)
- in_gr_we  in  1  writes a register
- in_dest  in  5  destination register
- out_allow_in  in  1  memory stage can accept
- out_valid  out  1  valid && ready_go && !flush
- out_pc, out_result  out  XLEN  PC and execute result
- out_res_from_mem, out_gr_we  out  1  passed through
- out_mem_size  out  2  passed through
- out_dest  out  5  passed through
- fwd_valid, fwd_gr_we  out  1  bypass qualifiers
- fwd_dest  out  5  bypass destination
- fwd_data  out  XLEN  equals out_result
- fwd_is_ld  out  1  valid && res_from_mem
- fwd_busy  out  1  valid && divide op && !ready_go; decode must stall on a match
- data_sram_en  out  1  memory request strobe
- data_sram_we  out  BE_W  store byte enables
- data_sram_addr  out  XLEN  address
- data_sram_wdata  out  XLEN  store data

Behaviour:
- Reset: all registers cleared.
  - valid, every output strobe, and data_sram_we are 0.
  - allow_in is 1.
  - Divider FSM is IDLE.
- Capture: on (allow_in && in_valid && !flush), all in_* fields are latched and valid is set.
  - When allow_in is 1 but no new instruction is captured, valid clears.
  - flush clears valid on the next edge and returns the FSM to IDLE, overriding every other event.
- Ops 0–11 are single-cycle, so ready_go=1.
  - Shift amount is src2[log2(XLEN)-1:0].
  - SLT/SLTU results are 0 or 1, zero-extended.
  - PASS2 returns src2.
- Divide ops 12–15: FSM IDLE -> BUSY -> DONE.
  - IDLE with a valid divide: load operand magnitudes; go to BUSY on the next edge.
  - BUSY: one restoring-division step per cycle for exactly XLEN cycles, tracked by a counter; then DONE.
  - DONE: ready_go=1. Stay in DONE while out_allow_in=0. Go to IDLE on handoff.
  - Residency is XLEN+2 cycles when downstream does not stall.
- Divide sign and corner cases:
  - Signed quotient sign = src1 sign XOR src2 sign; signed remainder takes the sign of src1.
  - Divide by zero: quotient = all ones, remainder = src1.
  - MIN / -1: quotient = MIN, remainder = 0.
- Memory request:
  - data_sram_en = valid && ready_go && out_allow_in && !flush && (mem_we || res_from_mem), so it fires exactly once per instruction.
  - data_sram_addr = out_result.
- Store enables:
  - data_sram_we = BE_W'b0 unless (data_sram_en && mem_we).
  - Byte: one-hot at addr[log2(BE_W)-1:0].
  - Half: two bytes at the half-aligned offset.
  - Word: four bytes.
  - Dword: all bytes.
  - Low address bits below the access size are ignored.
- wdata: store_data's low byte, half or word replicated across the bus.
- Back-to-back: a new instruction is accepted in the same cycle the current one hands off.

Test Plan:
- ADD 5+7, out_allow_in=1 -> out_valid in the cycle after capture, out_result=12, allow_in stays 1.
- DIV src1=-7, src2=2, XLEN=32 -> fwd_busy=1 for 33 cycles, then out_valid with result 0xFFFFFFFD. MOD of the same operands -> 0xFFFFFFFF.
- DIVU by 0 -> result 0xFFFFFFFF. MODU 9 by 0 -> 9. DIV 0x80000000 by -1 -> 0x80000000.
- Byte store to addr 0x1003, data 0xAB, out_allow_in held 0 for 3 cycles -> data_sram_en=0 while stalled, then a single strobe with we=4'b1000 and wdata=0xABABABAB.
- flush asserted in BUSY cycle 10 of a DIV -> out_valid never asserts, FSM returns to IDLE, and an ADD offered the following cycle completes normally.
- reset asserted mid-divide asynchronously -> valid, out_valid and data_sram_we drop to 0 immediately, and allow_in reads 1.
